// File: rtl/display_pkg.sv
// Shared types and constants for the vending display scheduler.
// Source indices, FSM encoding and priority helpers.
package display_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SHOW = 2'd1,
      ST_KEEP = 2'd2
   } state_e;

   localparam logic [1:0] SRC_BAL = 2'd0;
   localparam logic [1:0] SRC_CHG = 2'd1;
   localparam logic [1:0] SRC_ERR = 2'd2;

   localparam logic [3:0] BLANK = 4'hF;

   function automatic logic [1:0] prio_pick(
      input logic [2:0] r
   );
      logic [1:0] s;
      s = SRC_BAL;
      if (r[2])
         s = SRC_ERR;
      else if (r[1])
         s = SRC_CHG;
      return s;
   endfunction

   function automatic logic [2:0] src_onehot(
      input logic [1:0] s
   );
      logic [2:0] oh;
      oh = 3'b000;
      case (s)
         SRC_BAL: oh = 3'b001;
         SRC_CHG: oh = 3'b010;
         SRC_ERR: oh = 3'b100;
         default: oh = 3'b000;
      endcase
      return oh;
   endfunction

   // Requests that outrank the given owner.
   function automatic logic [2:0] higher_mask(
      input logic [1:0] s
   );
      logic [2:0] m;
      m = 3'b000;
      case (s)
         SRC_BAL: m = 3'b110;
         SRC_CHG: m = 3'b100;
         default: m = 3'b000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider: one-clk tick every DIV cycles.
// Tick is registered and follows the terminal count by one cycle.
module scan_tick_gen #(
   parameter int DIV = 25000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;
   logic          at_last;

   assign at_last = (cnt_q == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         tick  <= 1'b0;
      end else begin
         tick  <= at_last;
         cnt_q <= at_last ? '0 : cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/display_scheduler.sv
// Priority arbiter for the two-digit display: hold time,
// error blinking and scan tick generation.
module display_scheduler
   import display_pkg::*;
#(
   parameter int SCAN_DIV    = 25000,
   parameter int HOLD_TICKS  = 400,
   parameter int BLINK_TICKS = 200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] req,
   input  logic [3:0] val0,
   input  logic [3:0] val1,
   input  logic [3:0] val2,
   output logic [2:0] grant,
   output logic [3:0] display_num,
   output logic       display_tick,
   output logic       busy
);

   localparam int HW = $clog2(HOLD_TICKS + 1);
   localparam int BW = $clog2(BLINK_TICKS + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
   localparam logic [BW-1:0] BLNK_LAST = BW'(BLINK_TICKS - 1);

   // Async assert, two-flop synchronised release.
   logic [1:0] rst_sync_q;
   logic       rst_int_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rst_sync_q <= 2'b00;
      else
         rst_sync_q <= {rst_sync_q[0], 1'b1};
   end

   assign rst_int_n = rst_sync_q[1];

   logic tick;

   scan_tick_gen #(
      .DIV (SCAN_DIV)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_int_n),
      .tick  (tick)
   );

   assign display_tick = tick;

   state_e        state_q, state_d;
   logic [1:0]    own_q, own_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [BW-1:0] blink_q, blink_d;
   logic          phase_q, phase_d;
   logic [3:0]    val_q, val_d;
   logic [2:0]    grant_d;
   logic [3:0]    num_d;

   logic [1:0] top_src;
   logic [3:0] top_val;
   logic [3:0] own_val;
   logic       any_req;
   logic       own_req;
   logic       higher;
   logic       hold_done;
   logic       granting;

   assign top_src   = prio_pick(req);
   assign any_req   = |req;
   assign own_req   = |(req & src_onehot(own_q));
   assign higher    = |(req & higher_mask(own_q));
   assign hold_done = tick && (hold_q == HOLD_LAST);

   always_comb begin
      top_val = val0;
      case (top_src)
         SRC_CHG: top_val = val1;
         SRC_ERR: top_val = val2;
         default: top_val = val0;
      endcase
   end

   always_comb begin
      own_val = val0;
      case (own_q)
         SRC_CHG: own_val = val1;
         SRC_ERR: own_val = val2;
         default: own_val = val0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      own_d    = own_q;
      hold_d   = hold_q;
      blink_d  = blink_q;
      phase_d  = phase_q;
      val_d    = val_q;
      granting = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            granting = any_req;
         end
         ST_SHOW: begin
            // Error preemption outranks hold expiry.
            if (req[SRC_ERR] && own_q != SRC_ERR)
               granting = 1'b1;
            else if (hold_done) begin
               if (own_req && !higher)
                  state_d = ST_KEEP;
               else if (any_req)
                  granting = 1'b1;
               else
                  state_d = ST_IDLE;
            end else if (tick)
               hold_d = hold_q + HW'(1);
         end
         ST_KEEP: begin
            if (higher || (!own_req && any_req))
               granting = 1'b1;
            else if (!any_req)
               state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (granting) begin
         state_d = ST_SHOW;
         own_d   = top_src;
         hold_d  = '0;
         blink_d = '0;
         phase_d = 1'b0;
         val_d   = top_val;
      end else if (state_q != ST_IDLE) begin
         if (own_req)
            val_d = own_val;
         if (tick) begin
            if (blink_q == BLNK_LAST) begin
               blink_d = '0;
               phase_d = ~phase_q;
            end else
               blink_d = blink_q + BW'(1);
         end
      end

      grant_d = 3'b000;
      num_d   = BLANK;
      if (state_d != ST_IDLE) begin
         grant_d = src_onehot(own_d);
         if (!(own_d == SRC_ERR && phase_d))
            num_d = val_d;
      end
   end

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q     <= ST_IDLE;
         own_q       <= SRC_BAL;
         hold_q      <= '0;
         blink_q     <= '0;
         phase_q     <= 1'b0;
         val_q       <= BLANK;
         grant       <= 3'b000;
         display_num <= BLANK;
         busy        <= 1'b0;
      end else begin
         state_q     <= state_d;
         own_q       <= own_d;
         hold_q      <= hold_d;
         blink_q     <= blink_d;
         phase_q     <= phase_d;
         val_q       <= val_d;
         grant       <= grant_d;
         display_num <= num_d;
         busy        <= (state_d != ST_IDLE);
      end
   end

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with short timing
// parameters (SCAN_DIV=4, HOLD_TICKS=3, BLINK_TICKS=2).
module tb_display_scheduler;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] req;
   logic [3:0] val0;
   logic [3:0] val1;
   logic [3:0] val2;
   logic [2:0] grant;
   logic [3:0] display_num;
   logic       display_tick;
   logic       busy;

   int n_run = 0;
   int n_fail = 0;
   int phase = 0;

   typedef struct {
      logic [2:0] req;
      logic [3:0] v0;
      logic [3:0] v1;
      logic [3:0] v2;
      logic [2:0] g;
      logic [3:0] num;
   } vec_t;

   vec_t vq[$];

   always #5 clk = ~clk;

   display_scheduler #(
      .SCAN_DIV    (4),
      .HOLD_TICKS  (3),
      .BLINK_TICKS (2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req          (req),
      .val0         (val0),
      .val1         (val1),
      .val2         (val2),
      .grant        (grant),
      .display_num  (display_num),
      .display_tick (display_tick),
      .busy         (busy)
   );

   task automatic chk(input string name,
                      input logic [7:0] act,
                      input logic [7:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h",
                  name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      phase++;
   endtask

   task automatic add(input logic [2:0] r,
                      input logic [3:0] a,
                      input logic [3:0] b,
                      input logic [3:0] c,
                      input logic [2:0] g,
                      input logic [3:0] num,
                      input int n);
      for (int i = 0; i < n; i++)
         vq.push_back('{r, a, b, c, g, num});
   endtask

   // Entry i drives in aligned cycle T+i, checks cycle T+i+1.
   task automatic run_vecs(input string tag);
      foreach (vq[i]) begin
         req  = vq[i].req;
         val0 = vq[i].v0;
         val1 = vq[i].v1;
         val2 = vq[i].v2;
         step();
         chk($sformatf("%s[%0d] grant", tag, i),
             8'(grant), 8'(vq[i].g));
         chk($sformatf("%s[%0d] num", tag, i),
             8'(display_num), 8'(vq[i].num));
         chk($sformatf("%s[%0d] busy", tag, i),
             8'(busy), 8'(vq[i].g != 3'b000));
         chk($sformatf("%s[%0d] tick", tag, i),
             8'(display_tick), 8'(phase % 4 == 0));
      end
      vq.delete();
   endtask

   task automatic wait_tick(input string tag);
      int k;
      k = 0;
      do begin
         step();
         k++;
      end while (!display_tick && k < 20);
      if (!display_tick) begin
         n_run++;
         n_fail++;
         $display("FAIL %s wait_tick: got no tick, expected one within 20 cycles",
                  tag);
      end
      phase = 0;
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 3'b000;
      val0  = 4'h0;
      val1  = 4'h0;
      val2  = 4'h0;
      #12;
      chk("rst grant", 8'(grant), 8'h0);
      chk("rst num", 8'(display_num), 8'hF);
      chk("rst tick", 8'(display_tick), 8'h0);
      chk("rst busy", 8'(busy), 8'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Idle: tick every 4 cycles, display blank.
      wait_tick("idle");
      add(3'b000, 4'h0, 4'h0, 4'h0, 3'b000, 4'hF, 8);
      run_vecs("idle");

      // Single-cycle balance pulse held for 3 ticks, value frozen.
      wait_tick("pulse");
      add(3'b001, 4'h7, 4'h0, 4'h0, 3'b001, 4'h7, 1);
      add(3'b000, 4'h1, 4'h0, 4'h0, 3'b001, 4'h7, 11);
      add(3'b000, 4'h1, 4'h0, 4'h0, 3'b000, 4'hF, 1);
      run_vecs("pulse");

      // Change waits for balance hold; then error preempts and blinks.
      wait_tick("chg");
      add(3'b001, 4'h3, 4'h0, 4'h0, 3'b001, 4'h3, 1);
      add(3'b011, 4'h3, 4'h5, 4'h0, 3'b001, 4'h3, 11);
      add(3'b011, 4'h3, 4'h5, 4'h0, 3'b010, 4'h5, 1);
      add(3'b010, 4'h3, 4'h6, 4'h0, 3'b010, 4'h6, 1);
      add(3'b110, 4'h3, 4'h6, 4'h9, 3'b100, 4'h9, 6);
      add(3'b110, 4'h3, 4'h6, 4'h9, 3'b100, 4'hF, 8);
      add(3'b110, 4'h3, 4'h6, 4'h9, 3'b100, 4'h9, 8);
      add(3'b110, 4'h3, 4'h6, 4'h9, 3'b100, 4'hF, 1);
      add(3'b000, 4'h3, 4'h6, 4'h9, 3'b000, 4'hF, 1);
      run_vecs("chg_err");

      // Error arrives on the hold-expiry edge of balance.
      wait_tick("coinc");
      add(3'b001, 4'h2, 4'h0, 4'h0, 3'b001, 4'h2, 12);
      add(3'b101, 4'h2, 4'h0, 4'h4, 3'b100, 4'h4, 1);
      add(3'b101, 4'h2, 4'h0, 4'h4, 3'b100, 4'h4, 1);
      add(3'b000, 4'h2, 4'h0, 4'h8, 3'b100, 4'h4, 6);
      add(3'b000, 4'h2, 4'h0, 4'h8, 3'b100, 4'hF, 4);
      add(3'b000, 4'h2, 4'h0, 4'h8, 3'b000, 4'hF, 1);
      run_vecs("coinc");

      // Balance reaches KEEP, change then takes over at once.
      wait_tick("keep");
      add(3'b001, 4'h1, 4'h0, 4'h0, 3'b001, 4'h1, 13);
      add(3'b011, 4'h1, 4'h3, 4'h0, 3'b010, 4'h3, 1);
      add(3'b001, 4'h1, 4'h0, 4'h0, 3'b010, 4'h3, 1);
      run_vecs("keep");

      // Asynchronous reset in the middle of a change hold.
      #3;
      rst_n = 1'b0;
      req   = 3'b000;
      #1;
      chk("arst grant", 8'(grant), 8'h0);
      chk("arst num", 8'(display_num), 8'hF);
      chk("arst tick", 8'(display_tick), 8'h0);
      chk("arst busy", 8'(busy), 8'h0);
      step();
      step();
      rst_n = 1'b1;
      step();
      step();
      chk("rel grant", 8'(grant), 8'h0);
      chk("rel num", 8'(display_num), 8'hF);
      chk("rel busy", 8'(busy), 8'h0);

      // Divider restarts; hex digits above 9 pass through.
      wait_tick("post");
      add(3'b001, 4'hA, 4'h0, 4'h0, 3'b001, 4'hA, 1);
      add(3'b001, 4'hE, 4'h0, 4'h0, 3'b001, 4'hE, 1);
      run_vecs("post");

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/display_scheduler.md
# display_scheduler

Arbitrates the vending machine's display sources (balance, change due, error code) onto the single two-digit dynamic display. It picks one source by fixed priority and holds it on screen for a minimum time. It blinks the error source and generates the scan-rate tick that clocks the digit multiplexer. It sits between the vending control FSM and the dynamic display driver, whose `display_num` input it drives.

## Interface
- `SCAN_DIV`, default 25000: clk cycles per scan tick; legal range is 2 or more.
- `HOLD_TICKS`, default 400: minimum number of scan ticks a granted source stays displayed; legal range is 1 or more.
- `BLINK_TICKS`, default 200: scan ticks per blink half-period for the error source; legal range is 1 or more.
- `clk`  in  1  system clock, single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  3  display requests: bit 0 balance, bit 1 change, bit 2 error. Level-sensitive.
- `val0`, `val1`, `val2`  in  4 each  value for the matching requester.
- `grant`  out  3  one-hot owner of the display; 3'b000 when idle.
- `display_num`  out  4  value to the display driver; 4'hF means blank.
- `display_tick`  out  1  one-clk pulse every SCAN_DIV cycles, used as the display scan clock enable.
- `busy`  out  1  high whenever `grant` is not zero.

## Operation
- Fixed priority is error (2) > change (1) > balance (0).
- States:
  - IDLE: grant 0, display_num 4'hF.
  - SHOW: one source granted, hold counter running.
  - KEEP: hold satisfied; the source is still requesting and nothing higher is pending.
- IDLE → SHOW when any `req` bit is high. Grant goes to the highest-priority asserted bit. The hold counter is cleared.
- SHOW: the hold counter increments on each `display_tick`. When it reaches HOLD_TICKS:
  - If the owner's req is still high and no higher req is pending, go to KEEP.
  - Otherwise, if any req is high, re-arbitrate to SHOW with the highest pending source and clear the counter.
  - Otherwise go to IDLE.
- KEEP → SHOW (new owner) on any higher-priority req, or on the owner's req dropping while another req is high. KEEP → IDLE when all req are low.
- Preemption: error request rising while change or balance is in SHOW preempts immediately; the hold is not honoured. A change request never preempts balance during its hold.
- Value handling:
  - The value is sampled at grant.
  - It refreshes every clk while the owner's req is high.
  - It is frozen at the last sampled value once the owner's req drops, which covers the remainder of the hold.
- Blink applies to the error source only.
  - The blink counter counts display_ticks and resets at grant.
  - display_num alternates between the value (first half-period) and 4'hF every BLINK_TICKS ticks.
- Values 4'hA–4'hE pass through unchanged. The error source with value 4'hF displays blank continuously.

## Timing
- Reset values: grant 0, display_num 4'hF, display_tick 0, busy 0. The tick, hold and blink counters reset to 0 and the state to IDLE.
- Tick divider:
  - The counter runs 0..SCAN_DIV-1 continuously, regardless of state.
  - display_tick is high in the cycle after the counter equals SCAN_DIV-1, so the first tick occurs SCAN_DIV cycles after reset release.
- All outputs are registered.
- Latency: req sampled high at edge n gives grant, busy and display_num valid after edge n+1.
- Preemption latency is also one cycle.
- A req pulse of a single clk is honoured: it is granted and held for the full HOLD_TICKS.
- Simultaneous events: if hold expiry and preemption fall on the same cycle, preemption wins. A tick coinciding with grant is not counted.
- Reset assertion mid-display forces the reset values immediately (asynchronous). Reset deassertion is synchronised internally by a two-flop release.

## Structure
- The shared package `display_pkg` holds:
  - the state encoding (IDLE, SHOW, KEEP),
  - the requester index constants (SRC_BAL=0, SRC_CHG=1, SRC_ERR=2),
  - the blank code 4'hF.
- One sub-module, `scan_tick_gen`, contains the SCAN_DIV divider producing display_tick, reusable by other timed blocks.
- The priority encoder, hold counter and blink logic stay inline.

## Test plan
Use a bench with SCAN_DIV=4, HOLD_TICKS=3, BLINK_TICKS=2.
- Reset then idle: display_tick pulses every 4 cycles, grant=0, display_num=4'hF.
- req=3'b001 with val0=7: grant=001 and display_num=7 one cycle later. Drop req after 1 cycle: grant holds for 3 ticks, then IDLE with display_num=4'hF.
- Balance shown; raise req[1] with val1=5 during the hold: no switch until the hold expires, then grant=010 and display_num=5.
- Change shown; raise req[2] with val2=9: next cycle grant=100. display_num shows 9 for 2 ticks, 4'hF for 2 ticks, and repeats.
- Hold expiry and error request on the same cycle: the error is granted, with no extra cycle of the old owner.
- Assert rst_n low mid-SHOW: outputs go to reset values asynchronously. Two cycles after release, the state is IDLE.
